// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: shares one AXI4-Lite slave (the cache wrapper) between
// the instruction-fetch requester (s0) and the load/store requester (s1).
// One whole transaction (address, data, response) is granted at a time. The
// granted port's channels are routed combinationally onto the m_* port.
//
// Handshake rule used on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. Valid never waits on ready. Ready may depend
// on valid. Once a valid is raised it stays high until its handshake.
//
// o_dbg_state exposes the FSM state: 0=IDLE 1=RD_ADDR 2=RD_DATA 3=WR_REQ 4=WR_RESP.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [2:0]            s0_arprot,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [31:0]           s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s0_awaddr,
  input  logic [2:0]            s0_awprot,
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [31:0]           s0_wdata,
  input  logic [3:0]            s0_wstrb,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  output logic [1:0]            s0_bresp,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [2:0]            s1_arprot,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [31:0]           s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  input  logic [ADDR_WIDTH-1:0] s1_awaddr,
  input  logic [2:0]            s1_awprot,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [31:0]           s1_wdata,
  input  logic [3:0]            s1_wstrb,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic [1:0]            s1_bresp,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  // cache side
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // debug
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  state_t r_state;
  logic   r_grant;
  logic   r_last;
  logic   r_aw_done;
  logic   r_w_done;

  state_t w_state_nxt;
  logic   w_grant_nxt;
  logic   w_last_nxt;
  logic   w_aw_done_nxt;
  logic   w_w_done_nxt;
  logic   w_pick;
  logic   w_aw_hs;
  logic   w_w_hs;

  // Granted-port view of the requester inputs
  logic [ADDR_WIDTH-1:0] w_g_araddr;
  logic [2:0]            w_g_arprot;
  logic                  w_g_arvalid;
  logic                  w_g_rready;
  logic [ADDR_WIDTH-1:0] w_g_awaddr;
  logic [2:0]            w_g_awprot;
  logic                  w_g_awvalid;
  logic [31:0]           w_g_wdata;
  logic [3:0]            w_g_wstrb;
  logic                  w_g_wvalid;
  logic                  w_g_bready;

  // Granted-port view of the outputs back to the requester
  logic                  w_g_arready;
  logic [31:0]           w_g_rdata;
  logic [1:0]            w_g_rresp;
  logic                  w_g_rvalid;
  logic                  w_g_awready;
  logic                  w_g_wready;
  logic [1:0]            w_g_bresp;
  logic                  w_g_bvalid;

  logic w_req0;
  logic w_req1;

  assign w_req0 = s0_arvalid | s0_awvalid;
  assign w_req1 = s1_arvalid | s1_awvalid;

  assign w_g_araddr  = r_grant ? s1_araddr  : s0_araddr;
  assign w_g_arprot  = r_grant ? s1_arprot  : s0_arprot;
  assign w_g_arvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_g_rready  = r_grant ? s1_rready  : s0_rready;
  assign w_g_awaddr  = r_grant ? s1_awaddr  : s0_awaddr;
  assign w_g_awprot  = r_grant ? s1_awprot  : s0_awprot;
  assign w_g_awvalid = r_grant ? s1_awvalid : s0_awvalid;
  assign w_g_wdata   = r_grant ? s1_wdata   : s0_wdata;
  assign w_g_wstrb   = r_grant ? s1_wstrb   : s0_wstrb;
  assign w_g_wvalid  = r_grant ? s1_wvalid  : s0_wvalid;
  assign w_g_bready  = r_grant ? s1_bready  : s0_bready;

  // State, grant and write-progress registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Next-state logic and channel routing for the granted port
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_pick        = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;

    m_araddr  = '0;
    m_arprot  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awaddr  = '0;
    m_awprot  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;

    w_g_arready = 1'b0;
    w_g_rdata   = '0;
    w_g_rresp   = '0;
    w_g_rvalid  = 1'b0;
    w_g_awready = 1'b0;
    w_g_wready  = 1'b0;
    w_g_bresp   = '0;
    w_g_bvalid  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          if (w_req0 && w_req1) begin
            w_pick = FIXED_PRIO ? 1'b0 : ~r_last;
          end else begin
            w_pick = w_req1;
          end
          w_grant_nxt = w_pick;
          // A read request beats a write request from the same port
          if (w_pick ? s1_arvalid : s0_arvalid) begin
            w_state_nxt = ST_RD_ADDR;
          end else begin
            w_state_nxt = ST_WR_REQ;
          end
        end
      end

      ST_RD_ADDR: begin
        m_araddr    = w_g_araddr;
        m_arprot    = w_g_arprot;
        m_arvalid   = w_g_arvalid;
        w_g_arready = m_arready;
        if (w_g_arvalid && m_arready) begin
          w_state_nxt = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        w_g_rdata  = m_rdata;
        w_g_rresp  = m_rresp;
        w_g_rvalid = m_rvalid;
        m_rready   = w_g_rready;
        if (m_rvalid && w_g_rready) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end
      end

      ST_WR_REQ: begin
        m_awaddr    = w_g_awaddr;
        m_awprot    = w_g_awprot;
        m_awvalid   = w_g_awvalid & ~r_aw_done;
        w_g_awready = m_awready & ~r_aw_done;
        m_wdata     = w_g_wdata;
        m_wstrb     = w_g_wstrb;
        m_wvalid    = w_g_wvalid & ~r_w_done;
        w_g_wready  = m_wready & ~r_w_done;
        w_aw_hs     = m_awvalid & m_awready;
        w_w_hs      = m_wvalid & m_wready;
        // AW and W finish independently; move on once both have finished
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt   = ST_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end

      ST_WR_RESP: begin
        w_g_bresp  = m_bresp;
        w_g_bvalid = m_bvalid;
        m_bready   = w_g_bready;
        if (m_bvalid && w_g_bready) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The non-granted port sees all zeros
  assign s0_arready = ~r_grant & w_g_arready;
  assign s0_rdata   = r_grant ? '0 : w_g_rdata;
  assign s0_rresp   = r_grant ? '0 : w_g_rresp;
  assign s0_rvalid  = ~r_grant & w_g_rvalid;
  assign s0_awready = ~r_grant & w_g_awready;
  assign s0_wready  = ~r_grant & w_g_wready;
  assign s0_bresp   = r_grant ? '0 : w_g_bresp;
  assign s0_bvalid  = ~r_grant & w_g_bvalid;

  assign s1_arready = r_grant & w_g_arready;
  assign s1_rdata   = r_grant ? w_g_rdata : '0;
  assign s1_rresp   = r_grant ? w_g_rresp : '0;
  assign s1_rvalid  = r_grant & w_g_rvalid;
  assign s1_awready = r_grant & w_g_awready;
  assign s1_wready  = r_grant & w_g_wready;
  assign s1_bresp   = r_grant ? w_g_bresp : '0;
  assign s1_bvalid  = r_grant & w_g_bvalid;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1. A round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share the stimulus; each has its own reset
// so only one is active at a time.
module tb_axi_lite_arbiter_2to1;

  localparam int AW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_fp = 1'b1;
  always #5 clk = ~clk;

  // requester-side stimulus
  logic [AW-1:0] s0_araddr = '0, s1_araddr = '0, s0_awaddr = '0, s1_awaddr = '0;
  logic [2:0]    s0_arprot = '0, s1_arprot = '0, s0_awprot = '0, s1_awprot = '0;
  logic          s0_arvalid = 0, s1_arvalid = 0, s0_awvalid = 0, s1_awvalid = 0;
  logic          s0_rready = 0, s1_rready = 0, s0_bready = 0, s1_bready = 0;
  logic [31:0]   s0_wdata = '0, s1_wdata = '0;
  logic [3:0]    s0_wstrb = '0, s1_wstrb = '0;
  logic          s0_wvalid = 0, s1_wvalid = 0;

  // cache-side stimulus
  logic          m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0, m_bresp = '0;

  // dut outputs
  logic          s0_arready, s0_rvalid, s0_awready, s0_wready, s0_bvalid;
  logic          s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid;
  logic [31:0]   s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [2:0]    m_arprot, m_awprot, dbg_state;
  logic          m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;

  // dut_fp outputs
  logic          f_s0_arready, f_s0_rvalid, f_s0_awready, f_s0_wready, f_s0_bvalid;
  logic          f_s1_arready, f_s1_rvalid, f_s1_awready, f_s1_wready, f_s1_bvalid;
  logic [31:0]   f_s0_rdata, f_s1_rdata;
  logic [1:0]    f_s0_rresp, f_s1_rresp, f_s0_bresp, f_s1_bresp;
  logic [AW-1:0] f_m_araddr, f_m_awaddr;
  logic [2:0]    f_m_arprot, f_m_awprot, f_dbg_state;
  logic          f_m_arvalid, f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready;
  logic [31:0]   f_m_wdata;
  logic [3:0]    f_m_wstrb;

  axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_dbg_state(dbg_state)
  );

  axi_lite_arbiter_2to1 #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst_fp),
    .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(f_s0_arready),
    .s0_rdata(f_s0_rdata), .s0_rresp(f_s0_rresp), .s0_rvalid(f_s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(f_s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(f_s0_wready),
    .s0_bresp(f_s0_bresp), .s0_bvalid(f_s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(f_s1_arready),
    .s1_rdata(f_s1_rdata), .s1_rresp(f_s1_rresp), .s1_rvalid(f_s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(f_s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(f_s1_wready),
    .s1_bresp(f_s1_bresp), .s1_bvalid(f_s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(f_m_araddr), .m_arprot(f_m_arprot), .m_arvalid(f_m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(f_m_rready),
    .m_awaddr(f_m_awaddr), .m_awprot(f_m_awprot), .m_awvalid(f_m_awvalid), .m_awready(m_awready),
    .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_wvalid(f_m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(f_m_bready),
    .o_dbg_state(f_dbg_state)
  );

  int total = 0;
  int bad = 0;

  // handshake counters on the round-robin instance's cache port
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
    if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
    if (m_bvalid && m_bready)   b_cnt  <= b_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one read on dut, both ports requesting; g is the port expected to win
  task automatic rr_read(input logic g, input logic [31:0] data);
    tick();
    chk("rr_state_rd_addr", dbg_state, 64'd1);
    chk("rr_araddr", m_araddr, g ? 64'hB0 : 64'hA0);
    m_arready = 1;
    settle();
    chk("rr_s0_arready", s0_arready, !g);
    chk("rr_s1_arready", s1_arready, g);
    tick();
    m_arready = 0;
    m_rvalid = 1;
    m_rdata = data;
    settle();
    chk("rr_rdata_winner", g ? s1_rdata : s0_rdata, data);
    chk("rr_rvalid_loser", g ? s0_rvalid : s1_rvalid, 64'd0);
    tick();
    m_rvalid = 0;
    m_rdata = '0;
    chk("rr_back_idle", dbg_state, 64'd0);
  endtask

  int aw0, w0, b0;

  initial begin
    // reset
    tick(); tick();
    rst = 0;
    settle();
    chk("rst_state", dbg_state, 64'd0);
    chk("rst_m_arvalid", m_arvalid, 64'd0);
    chk("rst_m_rready", m_rready, 64'd0);
    chk("rst_s0_arready", s0_arready, 64'd0);
    chk("rst_s1_rvalid", s1_rvalid, 64'd0);
    chk("rst_m_araddr", m_araddr, 64'd0);

    // s0 read, cache arready after 2 cycles
    s0_araddr = 32'h0000_1000;
    s0_arvalid = 1;
    s0_rready = 1;
    settle();
    chk("t1_arb_cycle_no_fwd", m_arvalid, 64'd0);
    tick();
    chk("t1_m_arvalid", m_arvalid, 64'd1);
    chk("t1_m_araddr", m_araddr, 64'h1000);
    chk("t1_s0_arready_wait", s0_arready, 64'd0);
    tick();
    chk("t1_m_arvalid_held", m_arvalid, 64'd1);
    m_arready = 1;
    settle();
    chk("t1_s0_arready", s0_arready, 64'd1);
    chk("t1_s1_arready", s1_arready, 64'd0);
    tick();
    s0_arvalid = 0;
    m_arready = 0;
    chk("t1_state_rd_data", dbg_state, 64'd2);
    chk("t1_no_ar_in_data", m_arvalid, 64'd0);
    m_rvalid = 1;
    m_rdata = 32'hDEAD_BEEF;
    m_rresp = 2'd0;
    settle();
    chk("t1_s0_rdata", s0_rdata, 64'hDEADBEEF);
    chk("t1_s0_rresp", s0_rresp, 64'd0);
    chk("t1_s0_rvalid", s0_rvalid, 64'd1);
    chk("t1_m_rready", m_rready, 64'd1);
    chk("t1_s1_rvalid", s1_rvalid, 64'd0);
    chk("t1_s1_rdata", s1_rdata, 64'd0);
    tick();
    m_rvalid = 0;
    m_rdata = '0;
    chk("t1_back_idle", dbg_state, 64'd0);
    chk("t1_s0_rvalid_idle", s0_rvalid, 64'd0);

    // round-robin alternation from a fresh reset
    rst = 1;
    tick();
    rst = 0;
    s0_araddr = 32'hA0;
    s1_araddr = 32'hB0;
    s0_arvalid = 1;
    s1_arvalid = 1;
    s1_rready = 1;
    rr_read(1'b0, 32'h1111_0000);
    rr_read(1'b1, 32'h2222_0001);
    rr_read(1'b0, 32'h3333_0002);
    rr_read(1'b1, 32'h4444_0003);
    s0_arvalid = 0;
    s1_arvalid = 0;

    // s1 write, W accepted 3 cycles before AW
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    s1_awaddr = 32'h8000_0010;
    s1_wdata = 32'h1234_5678;
    s1_wstrb = 4'hF;
    s1_awvalid = 1;
    s1_wvalid = 1;
    s1_bready = 1;
    tick();
    chk("t3_state_wr_req", dbg_state, 64'd3);
    chk("t3_m_awvalid", m_awvalid, 64'd1);
    chk("t3_m_awaddr", m_awaddr, 64'h80000010);
    chk("t3_m_wdata", m_wdata, 64'h12345678);
    chk("t3_m_wstrb", m_wstrb, 64'hF);
    m_wready = 1;
    settle();
    chk("t3_s1_wready", s1_wready, 64'd1);
    chk("t3_s1_awready", s1_awready, 64'd0);
    chk("t3_s0_wready", s0_wready, 64'd0);
    tick();
    chk("t3_w_masked", m_wvalid, 64'd0);
    chk("t3_s1_wready_masked", s1_wready, 64'd0);
    chk("t3_s1_bvalid_early", s1_bvalid, 64'd0);
    tick();
    tick();
    chk("t3_still_wr_req", dbg_state, 64'd3);
    m_awready = 1;
    settle();
    chk("t3_s1_awready", s1_awready, 64'd1);
    tick();
    s1_awvalid = 0;
    s1_wvalid = 0;
    m_awready = 0;
    m_wready = 0;
    chk("t3_state_wr_resp", dbg_state, 64'd4);
    chk("t3_no_aw_in_resp", m_awvalid, 64'd0);
    m_bvalid = 1;
    m_bresp = 2'd0;
    settle();
    chk("t3_s1_bvalid", s1_bvalid, 64'd1);
    chk("t3_s1_bresp", s1_bresp, 64'd0);
    chk("t3_m_bready", m_bready, 64'd1);
    chk("t3_s0_bvalid", s0_bvalid, 64'd0);
    tick();
    m_bvalid = 0;
    chk("t3_back_idle", dbg_state, 64'd0);
    chk("t3_aw_once", aw_cnt - aw0, 64'd1);
    chk("t3_w_once", w_cnt - w0, 64'd1);
    chk("t3_b_once", b_cnt - b0, 64'd1);

    // s1 write with AW and W together while s0 holds a read
    s1_awaddr = 32'h8000_0020;
    s1_wdata = 32'hA5A5_5A5A;
    s1_awvalid = 1;
    s1_wvalid = 1;
    tick();
    chk("t4_state_wr_req", dbg_state, 64'd3);
    s0_araddr = 32'h2000;
    s0_arvalid = 1;
    m_awready = 1;
    m_wready = 1;
    settle();
    chk("t4_s1_awready", s1_awready, 64'd1);
    chk("t4_s1_wready", s1_wready, 64'd1);
    chk("t4_s0_arready", s0_arready, 64'd0);
    tick();
    s1_awvalid = 0;
    s1_wvalid = 0;
    m_awready = 0;
    m_wready = 0;
    chk("t4_state_wr_resp", dbg_state, 64'd4);
    m_bvalid = 1;
    m_bresp = 2'd2;
    settle();
    chk("t4_s1_bresp", s1_bresp, 64'd2);
    chk("t4_no_read_yet", m_arvalid, 64'd0);
    tick();
    m_bvalid = 0;
    m_bresp = 2'd0;
    chk("t4_idle_gap", dbg_state, 64'd0);
    chk("t4_idle_no_ar", m_arvalid, 64'd0);
    tick();
    chk("t4_read_starts", m_arvalid, 64'd1);
    chk("t4_read_addr", m_araddr, 64'h2000);
    m_arready = 1;
    tick();
    s0_arvalid = 0;
    m_arready = 0;
    m_rvalid = 1;
    m_rdata = 32'h0000_55AA;
    settle();
    chk("t4_s0_rdata", s0_rdata, 64'h55AA);
    tick();
    m_rvalid = 0;
    m_rdata = '0;

    // reset while waiting for read data
    s0_araddr = 32'h2400;
    s0_arvalid = 1;
    tick();
    m_arready = 1;
    tick();
    s0_arvalid = 0;
    m_arready = 0;
    chk("t6_in_rd_data", dbg_state, 64'd2);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_rst_state", dbg_state, 64'd0);
    chk("t6_rst_m_rready", m_rready, 64'd0);
    chk("t6_rst_m_arvalid", m_arvalid, 64'd0);
    m_rvalid = 1;
    m_rdata = 32'hBAD0_BAD0;
    settle();
    chk("t6_no_stale_rvalid", s0_rvalid, 64'd0);
    chk("t6_no_stale_rdata", s0_rdata, 64'd0);
    m_rvalid = 0;
    m_rdata = '0;
    s1_araddr = 32'h3000;
    s1_arvalid = 1;
    tick();
    chk("t6_s1_rd_addr", dbg_state, 64'd1);
    chk("t6_s1_araddr", m_araddr, 64'h3000);
    m_arready = 1;
    settle();
    chk("t6_s1_arready", s1_arready, 64'd1);
    tick();
    s1_arvalid = 0;
    m_arready = 0;
    m_rvalid = 1;
    m_rdata = 32'hCAFE_F00D;
    m_rresp = 2'd1;
    settle();
    chk("t6_s1_rdata", s1_rdata, 64'hCAFEF00D);
    chk("t6_s1_rresp", s1_rresp, 64'd1);
    tick();
    m_rvalid = 0;
    m_rdata = '0;
    m_rresp = '0;
    chk("t6_done_idle", dbg_state, 64'd0);

    // fixed priority: both request continuously, s0 wins every time
    rst = 1;
    rst_fp = 0;
    s0_araddr = 32'hA0;
    s1_araddr = 32'hB0;
    s0_arvalid = 1;
    s1_arvalid = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_state_rd_addr", f_dbg_state, 64'd1);
      chk("fp_araddr_s0", f_m_araddr, 64'hA0);
      m_arready = 1;
      settle();
      chk("fp_s0_arready", f_s0_arready, 64'd1);
      chk("fp_s1_arready", f_s1_arready, 64'd0);
      tick();
      m_arready = 0;
      m_rvalid = 1;
      m_rdata = 32'h0F00 + k;
      settle();
      chk("fp_s0_rdata", f_s0_rdata, 64'h0F00 + k);
      chk("fp_s1_rvalid", f_s1_rvalid, 64'd0);
      tick();
      m_rvalid = 0;
      m_rdata = '0;
    end
    s0_arvalid = 0;
    s1_arvalid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Shares the single AXI4-Lite slave port of the cache wrapper between two requesters: s0 (instruction fetch) and s1 (load/store unit).
- Grants one whole transaction at a time (address, data and response phases), with round-robin or fixed priority.
- Routes the granted port's channels combinationally onto the m_* port that feeds the cache.
- Sits between the core and the cache wrapper.

Parameters:
- ADDR_WIDTH, 32, width of araddr/awaddr on all ports.
- FIXED_PRIO, 0: 0 = round-robin; 1 = s0 always wins ties.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- sN_araddr/sN_arprot/sN_arvalid  in  ADDR_WIDTH/3/1  read address from requester N (N = 0,1).
- sN_arready  out  1  read-address accept to requester N.
- sN_rdata/sN_rresp/sN_rvalid  out  32/2/1  read data to requester N.
- sN_rready  in  1  read data accept from requester N.
- sN_awaddr/sN_awprot/sN_awvalid  in  ADDR_WIDTH/3/1  write address from requester N.
- sN_awready  out  1  write-address accept to requester N.
- sN_wdata/sN_wstrb/sN_wvalid  in  32/4/1  write data from requester N.
- sN_wready  out  1  write-data accept to requester N.
- sN_bresp/sN_bvalid  out  2/1  write response to requester N.
- sN_bready  in  1  write response accept from requester N.
- m_araddr/m_arprot/m_arvalid  out  ADDR_WIDTH/3/1  to cache read address.
- m_arready  in  1  cache read-address accept.
- m_rdata/m_rresp/m_rvalid  in  32/2/1  from cache read data.
- m_rready  out  1  read data accept to cache.
- m_awaddr/m_awprot/m_awvalid  out  ADDR_WIDTH/3/1  to cache write address.
- m_awready  in  1  cache write-address accept.
- m_wdata/m_wstrb/m_wvalid  out  32/4/1  to cache write data.
- m_wready  in  1  cache write-data accept.
- m_bresp/m_bvalid  in  2/1  from cache write response.
- m_bready  out  1  write response accept to cache.

Behaviour:
- Registered state: state {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP}; grant (1 bit); last (1 bit); aw_done, w_done.
- Reset (rst=1 at a clock edge): state=IDLE, grant=0, last=1, aw_done=w_done=0.
  - All m_*valid, m_rready, m_bready, sN_*ready and sN_*valid are 0.
  - All data/address outputs are 0.
  - Reset mid-transaction abandons it with no completion to either port.
- Request for port N: reqN = sN_arvalid | sN_awvalid.
- IDLE arbitration:
  - Only one port requesting: grant it.
  - Both requesting: with FIXED_PRIO=0, grant = ~last; with FIXED_PRIO=1, grant = 0.
  - Winner has arvalid: go to RD_ADDR. Otherwise go to WR_REQ. Read wins over write within one port.
  - Arbitration costs exactly 1 cycle; nothing is forwarded while in IDLE.
- RD_ADDR:
  - m_ar* = s[grant]_ar*; s[grant]_arready = m_arready.
  - On m_arvalid & m_arready, go to RD_DATA.
- RD_DATA:
  - s[grant]_r* = m_r*; m_rready = s[grant]_rready.
  - On m_rvalid & m_rready: go to IDLE, last = grant.
- WR_REQ:
  - AW path: m_awvalid = s[grant]_awvalid & ~aw_done; s[grant]_awready = m_awready & ~aw_done.
  - W path: same rule using w_done. m_aw*/m_w* data fields come from s[grant].
  - Each handshake sets its done flag. AW and W may complete in the same cycle or in either order.
  - When both are complete (flag or same-cycle handshake): go to WR_RESP and clear both flags.
- WR_RESP:
  - s[grant]_b* = m_b*; m_bready = s[grant]_bready.
  - On the b handshake: go to IDLE, last = grant.
- Non-granted port, and every port while in IDLE: all its ready/valid outputs are 0.
- Single outstanding transaction; no reordering. Back-to-back transactions from one port have a minimum 1 idle cycle between them.
- A valid deasserted before its handshake violates AXI; behaviour in that case is not checked.

Test Plan:
- s0 read only, araddr=0x0000_1000, cache arready after 2 cycles, rdata=0xDEADBEEF → s0_rdata=0xDEADBEEF, rresp=0; s1 outputs stay 0; 1 cycle from arvalid to m_arvalid.
- s0 and s1 both raise arvalid in the same cycle after reset (FIXED_PRIO=0) → s0 served first. Next both-request goes to s1, then s0 (strict alternation over 4 transactions).
- s1 write awaddr=0x8000_0010, wdata=0x12345678, wstrb=0xF; cache wready 3 cycles before awready → each handshake exactly once; s1_bvalid with bresp=0 only after both complete.
- s1 write with AW and W accepted in the same cycle, while s0 arvalid is held → s0's read starts only after s1's b handshake plus the 1-cycle IDLE.
- FIXED_PRIO=1, both ports request continuously for 3 transactions → all granted to s0; s1 never granted while s0 requests.
- rst asserted in RD_DATA before rvalid → next cycle state IDLE, all valids/readies 0; a fresh s1 read then completes normally.
